// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: operand-forwarding selects, load-use bubble sequencing,
// memory-busy freeze and a saturating stall/freeze cycle counter.
// Optional feature macro: FWD_WB_OUT_EN adds a lowest-priority WB/OUT
// forwarding source (select 11) and its wb_out_rd / wb_out_regWrite ports.
module hazard_forward_ctrl #(
    parameter int REG_AW          = 5,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int STALL_CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_AW-1:0]      if_id_rs1,
    input  logic [REG_AW-1:0]      if_id_rs2,
    input  logic [REG_AW-1:0]      id_ex_rs1,
    input  logic [REG_AW-1:0]      id_ex_rs2,
    input  logic [REG_AW-1:0]      id_ex_rd,
    input  logic                   id_ex_memRead,
    input  logic [REG_AW-1:0]      ex_mem_rd,
    input  logic                   ex_mem_regWrite,
    input  logic [REG_AW-1:0]      mem_wb_rd,
    input  logic                   mem_wb_regWrite,
`ifdef FWD_WB_OUT_EN
    input  logic [REG_AW-1:0]      wb_out_rd,
    input  logic                   wb_out_regWrite,
`endif
    input  logic                   mem_busy,
    output logic [1:0]             forward_a,
    output logic [1:0]             forward_b,
    output logic                   stall,
    output logic                   bubble,
    output logic                   freeze,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic {RUN, LU_STALL} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             lu_cnt_q, lu_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Per-stage producer hit: stage writes a non-zero rd that matches the source.
    logic ex_a, ex_b, wb_a, wb_b, out_a, out_b;
    logic load_use;

    // Forwarding match terms and load-use detection.
    always_comb begin
        ex_a  = ex_mem_regWrite && (ex_mem_rd != '0) && (ex_mem_rd == id_ex_rs1);
        ex_b  = ex_mem_regWrite && (ex_mem_rd != '0) && (ex_mem_rd == id_ex_rs2);
        wb_a  = mem_wb_regWrite && (mem_wb_rd != '0) && (mem_wb_rd == id_ex_rs1);
        wb_b  = mem_wb_regWrite && (mem_wb_rd != '0) && (mem_wb_rd == id_ex_rs2);
`ifdef FWD_WB_OUT_EN
        out_a = wb_out_regWrite && (wb_out_rd != '0) && (wb_out_rd == id_ex_rs1);
        out_b = wb_out_regWrite && (wb_out_rd != '0) && (wb_out_rd == id_ex_rs2);
`else
        out_a = 1'b0;
        out_b = 1'b0;
`endif
        load_use = id_ex_memRead && (id_ex_rd != '0) &&
                   ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
    end

    // Operand selects: youngest producer wins; forced to regfile during reset.
    always_comb begin
        forward_a = 2'b00;
        forward_b = 2'b00;
        if (!rst) begin
            if (ex_a)       forward_a = 2'b10;
            else if (wb_a)  forward_a = 2'b01;
            else if (out_a) forward_a = 2'b11;
            if (ex_b)       forward_b = 2'b10;
            else if (wb_b)  forward_b = 2'b01;
            else if (out_b) forward_b = 2'b11;
        end
    end

    // Next state and control outputs; a busy memory freezes everything.
    always_comb begin
        state_d  = state_q;
        lu_cnt_d = lu_cnt_q;
        stall    = 1'b0;
        bubble   = 1'b0;
        freeze   = 1'b0;
        if (rst) begin
            state_d  = RUN;
            lu_cnt_d = '0;
        end else if (mem_busy) begin
            freeze = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (load_use) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                        // First bubble is issued here; the rest come from LU_STALL.
                        if (LOAD_USE_CYCLES > 1) begin
                            state_d  = LU_STALL;
                            lu_cnt_d = 4'(LOAD_USE_CYCLES - 2);
                        end
                    end
                end
                LU_STALL: begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    if (lu_cnt_q == '0) state_d  = RUN;
                    else                lu_cnt_d = lu_cnt_q - 4'd1;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Saturating count of cycles spent stalled or frozen.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((stall || freeze) && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            lu_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lu_cnt_q    <= lu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed-vector bench for hazard_forward_ctrl (LOAD_USE_CYCLES=3, STALL_CNT_W=4).
module tb_hazard_forward_ctrl;

    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] if_id_rs1, if_id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic          id_ex_memRead;
    logic [AW-1:0] ex_mem_rd, mem_wb_rd;
    logic          ex_mem_regWrite, mem_wb_regWrite;
    logic [AW-1:0] wb_out_rd;
    logic          wb_out_regWrite;
    logic          mem_busy;
    logic [1:0]    forward_a, forward_b;
    logic          stall, bubble, freeze;
    logic [CW-1:0] stall_cnt;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    hazard_forward_ctrl #(.REG_AW(AW), .LOAD_USE_CYCLES(3), .STALL_CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_memRead(id_ex_memRead),
        .ex_mem_rd(ex_mem_rd), .ex_mem_regWrite(ex_mem_regWrite),
        .mem_wb_rd(mem_wb_rd), .mem_wb_regWrite(mem_wb_regWrite),
`ifdef FWD_WB_OUT_EN
        .wb_out_rd(wb_out_rd), .wb_out_regWrite(wb_out_regWrite),
`endif
        .mem_busy(mem_busy),
        .forward_a(forward_a), .forward_b(forward_b),
        .stall(stall), .bubble(bubble), .freeze(freeze),
        .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge; inputs change there and checks run 1 time unit later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        if_id_rs1 = '0; if_id_rs2 = '0; id_ex_rs1 = '0; id_ex_rs2 = '0; id_ex_rd = '0;
        id_ex_memRead = 1'b0; ex_mem_rd = '0; mem_wb_rd = '0;
        ex_mem_regWrite = 1'b0; mem_wb_regWrite = 1'b0;
        wb_out_rd = '0; wb_out_regWrite = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic do_reset();
        step(); rst = 1'b1;
        step(); rst = 1'b0;
    endtask

    task automatic set_lu();
        id_ex_memRead = 1'b1; id_ex_rd = 5'd5; if_id_rs2 = 5'd5;
    endtask

    task automatic clr_lu();
        id_ex_memRead = 1'b0; id_ex_rd = '0; if_id_rs2 = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        // Reset gating: every hazard/forward condition active while rst=1.
        step();
        set_lu(); mem_busy = 1'b1;
        id_ex_rs1 = 5'd9; id_ex_rs2 = 5'd9; ex_mem_rd = 5'd9; ex_mem_regWrite = 1'b1;
        #1;
        chk("rst_stall",  stall,     0);
        chk("rst_bubble", bubble,    0);
        chk("rst_freeze", freeze,    0);
        chk("rst_fwd_a",  forward_a, 0);
        chk("rst_fwd_b",  forward_b, 0);
        step(); idle(); rst = 1'b0; #1;
        chk("rst_cnt", stall_cnt, 0);

        // No hazard.
        id_ex_rs1 = 5'd1; id_ex_rs2 = 5'd2; ex_mem_rd = 5'd3; mem_wb_rd = 5'd4;
        ex_mem_regWrite = 1'b1; mem_wb_regWrite = 1'b1; #1;
        chk("nohaz_a", forward_a, 2'b00);
        chk("nohaz_b", forward_b, 2'b00);
        chk("nohaz_stall", stall, 0);

        // Priority EX/MEM > MEM/WB > none.
        id_ex_rs1 = 5'd9; id_ex_rs2 = 5'd9; ex_mem_rd = 5'd9; mem_wb_rd = 5'd9; #1;
        chk("prio_ex_a", forward_a, 2'b10);
        chk("prio_ex_b", forward_b, 2'b10);
        ex_mem_regWrite = 1'b0; #1;
        chk("prio_wb_a", forward_a, 2'b01);
        chk("prio_wb_b", forward_b, 2'b01);
        ex_mem_regWrite = 1'b1; ex_mem_rd = '0; mem_wb_rd = '0; #1;
        chk("rd0_a", forward_a, 2'b00);
        chk("rd0_b", forward_b, 2'b00);

        // Independent operands: A from EX/MEM, B from MEM/WB.
        id_ex_rs1 = 5'd3; id_ex_rs2 = 5'd4; ex_mem_rd = 5'd3; mem_wb_rd = 5'd4; #1;
        chk("indep_a", forward_a, 2'b10);
        chk("indep_b", forward_b, 2'b01);

        // WB/OUT source at lowest priority (or absent).
        idle();
        id_ex_rs1 = 5'd7; wb_out_rd = 5'd7; wb_out_regWrite = 1'b1; #1;
`ifdef FWD_WB_OUT_EN
        chk("wbout_a", forward_a, 2'b11);
        mem_wb_rd = 5'd7; mem_wb_regWrite = 1'b1; #1;
        chk("wbout_lose_a", forward_a, 2'b01);
`else
        chk("wbout_off_a", forward_a, 2'b00);
`endif
        idle();

        // Load-use: three bubble cycles, then clear.
        do_reset();
        set_lu(); #1;
        chk("lu_c1_stall",  stall,  1);
        chk("lu_c1_bubble", bubble, 1);
        step(); clr_lu(); #1;
        chk("lu_c2_stall",  stall,  1);
        chk("lu_c2_bubble", bubble, 1);
        step(); #1;
        chk("lu_c3_stall",  stall,  1);
        step(); #1;
        chk("lu_done_stall",  stall,  0);
        chk("lu_done_bubble", bubble, 0);
        chk("lu_cnt", stall_cnt, 3);

        // Back-to-back sequences: LU held through the exit keeps stalling.
        do_reset();
        set_lu();
        step(); step(); step(); #1;
        chk("b2b_restart", bubble, 1);
        clr_lu();

        // Freeze during the second bubble cycle.
        do_reset();
        set_lu(); #1;
        chk("frz_b1", bubble, 1);
        step(); clr_lu(); mem_busy = 1'b1; #1;
        chk("frz_f1_freeze", freeze, 1);
        chk("frz_f1_stall",  stall,  0);
        chk("frz_f1_bubble", bubble, 0);
        step(); #1;
        chk("frz_f2_freeze", freeze, 1);
        step(); mem_busy = 1'b0; #1;
        chk("frz_b2", bubble, 1);
        chk("frz_b2_freeze", freeze, 0);
        step(); #1;
        chk("frz_b3", bubble, 1);
        step(); #1;
        chk("frz_done", stall, 0);
        chk("frz_cnt", stall_cnt, 5);

        // Reset mid LU_STALL aborts the sequence.
        do_reset();
        set_lu();
        step(); clr_lu(); #1;
        chk("rms_in_stall", stall, 1);
        step(); rst = 1'b1; #1;
        chk("rms_rst_stall",  stall,  0);
        chk("rms_rst_bubble", bubble, 0);
        step(); rst = 1'b0; #1;
        chk("rms_after_stall", stall, 0);
        chk("rms_after_cnt", stall_cnt, 0);
        step(); #1;
        chk("rms_after2_bubble", bubble, 0);

        // Saturation of the 4-bit counter.
        do_reset();
        mem_busy = 1'b1;
        for (int i = 0; i < 20; i++) step();
        #1;
        chk("sat_15", stall_cnt, 15);
        step(); #1;
        chk("sat_hold", stall_cnt, 15);
        mem_busy = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/hazard_forward_ctrl.md
HAZARD_FORWARD_CTRL -- requirements
Module: hazard_forward_ctrl

Interface
REQ-001 Parameter REG_AW, default 5: register-address width.
REQ-002 Parameter LOAD_USE_CYCLES, default 1 (legal 1..15): bubble cycles inserted per load-use hazard.
REQ-003 Parameter STALL_CNT_W, default 16: width of stall_cnt.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 if_id_rs1, if_id_rs2  in  REG_AW  source registers of the instruction in ID.
REQ-007 id_ex_rs1, id_ex_rs2, id_ex_rd  in  REG_AW  sources/destination of the instruction in EX.
REQ-008 id_ex_memRead  in  1  EX instruction is a load.
REQ-009 ex_mem_rd, mem_wb_rd  in  REG_AW; ex_mem_regWrite, mem_wb_regWrite  in  1  producer info.
REQ-010 mem_busy  in  1  data memory has not completed its access this cycle.
REQ-011 forward_a, forward_b  out  2  ALU operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB, 11 WB/OUT.
REQ-012 stall  out  1  hold PC and IF/ID.
REQ-013 bubble  out  1  zero ID/EX control fields.
REQ-014 freeze  out  1  hold every pipeline register.
REQ-015 stall_cnt  out  STALL_CNT_W  saturating count of cycles with stall or freeze high.

Function
REQ-016 Forwarding is combinational: a source matches a stage when that stage's regWrite=1, its rd!=0 and rd equals the source.
REQ-017 Priority per operand: EX/MEM (10) > MEM/WB (01) > WB/OUT (11, macro only) > 00; operands A and B are decided independently.
REQ-018 Load-use hazard (LU) = id_ex_memRead & id_ex_rd!=0 & (id_ex_rd==if_id_rs1 | id_ex_rd==if_id_rs2).
REQ-019 FSM states: RUN, LU_STALL; 4-bit down-counter lu_cnt.
REQ-020 RUN, mem_busy=0, LU=1: stall=1, bubble=1 in the same cycle; if LOAD_USE_CYCLES>1, next state LU_STALL with lu_cnt=LOAD_USE_CYCLES-2; otherwise remain in RUN.
REQ-021 LU_STALL, mem_busy=0: stall=1, bubble=1; if lu_cnt==0, next state is RUN; else lu_cnt decrements.
REQ-022 In any state, mem_busy=1: freeze=1, stall=0, bubble=0; state and lu_cnt hold; forward_a/forward_b still reflect the inputs.
REQ-023 freeze is combinational from mem_busy (zero-cycle latency); stall and bubble are combinational from state and inputs.
REQ-024 stall_cnt increments by 1 each cycle in which (stall|freeze)=1 and holds at all-ones (no wrap).
REQ-025 A LU detected in the cycle after LU_STALL exits starts a new sequence with no gap cycle.

Reset
REQ-026 While rst=1 at a clock edge: state=RUN, lu_cnt=0, stall_cnt=0.
REQ-027 While rst=1: stall=0, bubble=0, freeze=0, forward_a=00, forward_b=00, regardless of the other inputs.
REQ-028 An rst asserted during LU_STALL or a freeze aborts it; the first cycle after rst deasserts is in RUN.

Configuration
REQ-029 Macro FWD_WB_OUT_EN defined: adds input ports wb_out_rd (REG_AW) and wb_out_regWrite (1), and enables the 11 forwarding source at lowest priority.
REQ-030 FWD_WB_OUT_EN undefined: those ports are absent and forward_a/forward_b never equal 11.

Verification
REQ-031 No hazard: id_ex_rs1=1, id_ex_rs2=2, ex_mem_rd=3, mem_wb_rd=4, both regWrite=1 -> forward_a=00, forward_b=00, stall=0.
REQ-032 Priority: id_ex_rs1=id_ex_rs2=9, ex_mem_rd=mem_wb_rd=9, both regWrite=1 -> 10/10; set ex_mem_regWrite=0 -> 01/01; set all rd=0 -> 00/00.
REQ-033 LU with LOAD_USE_CYCLES=3: id_ex_memRead=1, id_ex_rd=5, if_id_rs2=5 -> stall=bubble=1 for exactly 3 consecutive cycles, then 0; stall_cnt=3.
REQ-034 Freeze mid-stall (LOAD_USE_CYCLES=3): mem_busy=1 for 2 cycles during the 2nd bubble cycle -> freeze=1, stall=bubble=0 for those 2 cycles, then the remaining 2 bubble cycles; stall_cnt=5.
REQ-035 Reset mid-stall: rst=1 for 1 cycle during LU_STALL with the LU condition removed -> stall=bubble=0 from the rst cycle onward and stall_cnt=0.
REQ-036 Saturation (STALL_CNT_W=4) and macro: hold mem_busy=1 for 20 cycles -> stall_cnt=15 and it stays 15; with FWD_WB_OUT_EN defined, wb_out_rd=7, wb_out_regWrite=1, id_ex_rs1=7, no other matching source -> forward_a=11.
